ddr_loopback_emu: RTL
=====================

Name: ddr_loopback_emu

Overview:
- Behavioural stand-in for the DDR3 controller side of the write-FIFO/read-FIFO interface.
- Drains bursts from the write FIFO into an internal circular memory, then streams them back in order into the read FIFO while rd_mem_enable is high.
- Generates calib_done after a fixed delay, so the test-data generator/validator can be closed in a loop without the MIG core.
- Synthesizable; used in simulation and in on-board FIFO-path bring-up.

Parameters:
DATA_W, 16, word width of both FIFO data paths
BURST_LEN, 64, words per write or read burst (power of two, ≤ MEM_DEPTH/2)
MEM_ADDR_W, 10, internal memory address width; MEM_DEPTH = 2^MEM_ADDR_W words
CNT_W, 11, width of FIFO occupancy count inputs
RFIFO_DEPTH, 1024, read-FIFO capacity in words
CALIB_CYCLES, 30, clocks from reset release to calib_done

Ports:
clk  in  1  system clock, shared with both FIFOs
rst_n  in  1  asynchronous active-low reset
calib_done  out  1  emulated DDR3 initialisation complete
wfifo_rd_en  out  1  write-FIFO read enable
wfifo_dout  in  DATA_W  write-FIFO data; valid one clock after wfifo_rd_en (standard, non-FWFT)
wfifo_rd_cnt  in  CNT_W  words currently held in the write FIFO
rd_mem_enable  in  1  read bursts permitted when high
rfifo_wr_en  out  1  read-FIFO write enable
rfifo_din  out  DATA_W  read-FIFO write data
rfifo_wr_cnt  in  CNT_W  words currently held in the read FIFO
stored_cnt  out  MEM_ADDR_W+1  words written but not yet read back
busy  out  1  high while in WR_BURST or RD_BURST

Behaviour:
Reset (asynchronous):
- All outputs 0.
- wr_ptr, rd_ptr, stored_cnt and calib counter cleared; state = CALIB.
- Memory contents are don't-care.
- Reset mid-burst aborts the burst immediately; no partial-burst resume.

State machine:
- CALIB:
  - Counts CALIB_CYCLES clocks, then enters IDLE.
  - calib_done registered high on entry to IDLE and stays high until reset.
- IDLE: evaluated every clock.
  - wr_ok = wfifo_rd_cnt ≥ BURST_LEN AND (MEM_DEPTH − stored_cnt) ≥ BURST_LEN.
  - rd_ok = rd_mem_enable AND stored_cnt ≥ BURST_LEN AND (RFIFO_DEPTH − rfifo_wr_cnt) ≥ BURST_LEN.
  - Only wr_ok → WR_BURST. Only rd_ok → RD_BURST.
  - Both → the opposite of the last burst type (round-robin). After reset, write wins.
- WR_BURST:
  - wfifo_rd_en high for exactly BURST_LEN consecutive clocks.
  - Each wfifo_dout arrives one clock later and is written to mem[wr_ptr]; wr_ptr increments per word.
  - Lasts BURST_LEN+1 clocks (trailing capture cycle), then back to IDLE.
- RD_BURST:
  - Synchronous memory read issued at rd_ptr for BURST_LEN consecutive clocks.
  - rfifo_wr_en/rfifo_din follow one clock after each address, giving exactly BURST_LEN write pulses.
  - Lasts BURST_LEN+1 clocks, then back to IDLE.
- rd_mem_enable is sampled only in IDLE; deasserting it mid-burst does not truncate the burst.

Pointers and counts:
- wr_ptr and rd_ptr are MEM_ADDR_W bits and wrap naturally from MEM_DEPTH−1 to 0.
- stored_cnt += BURST_LEN when the last word of a write burst is stored.
- stored_cnt −= BURST_LEN when the last address of a read burst is issued.
- The two updates never coincide because bursts are serialised.
- stored_cnt never exceeds MEM_DEPTH.

Ordering and timing:
- Data leaves in exactly the order it was accepted; no reordering, duplication or loss.
- Minimum 1 IDLE clock between bursts.
- Occupancy checks make overflow and underflow of both FIFOs impossible, given each count input lags by ≤1 clock. Counts are sampled only in IDLE.
- busy is high throughout WR_BURST and RD_BURST, including the trailing cycle.

Test Plan:
- Reset release, CALIB_CYCLES=30 → calib_done rises on the 31st rising edge after rst_n high; no FIFO enables before that.
- Write FIFO holds 64 words 0..63, rd_mem_enable=0 → 64 consecutive wfifo_rd_en pulses; stored_cnt goes 0→64; rfifo_wr_en stays 0.
- Then rd_mem_enable=1, read FIFO empty → 64 rfifo_wr_en pulses carrying 0..63 in order; stored_cnt back to 0.
- Continuous ramp 0..4095 with read-FIFO drained by the generator → 4096 words returned in order across pointer wrap at 1024; both-eligible cases alternate write/read.
- 16 write bursts with rd_mem_enable=0 → stored_cnt=1024; a further 64 words in the write FIFO are not read (wfifo_rd_en stays 0) until a read burst frees space.
- rst_n pulsed low at word 20 of a write burst → all outputs 0 immediately; calib_done reasserts after 30 clocks; stored_cnt=0.

Source files
------------

// File: rtl/ddr_loopback_if.sv
// FIFO-side bundle between the DDR loopback emulator and the write/read FIFOs.
//
// Handshake semantics (both paths are enable-strobed, no back-pressure wires):
//   - wfifo_rd_en is a pop strobe; the popped word appears on wfifo_dout one
//     clock later (standard, non-first-word-fall-through FIFO). The emulator
//     only pops when wfifo_rd_cnt already guarantees a full burst is present.
//   - rfifo_wr_en qualifies rfifo_din on the same clock; the emulator only
//     starts a read burst when rfifo_wr_cnt leaves room for the whole burst.
//   - The occupancy counts may lag the real FIFO state by at most one clock.
interface ddr_loopback_if #(
    parameter int DATA_W     = 16,
    parameter int CNT_W      = 11,
    parameter int MEM_ADDR_W = 10
);
    logic                  calib_done;
    logic                  wfifo_rd_en;
    logic [DATA_W-1:0]     wfifo_dout;
    logic [CNT_W-1:0]      wfifo_rd_cnt;
    logic                  rd_mem_enable;
    logic                  rfifo_wr_en;
    logic [DATA_W-1:0]     rfifo_din;
    logic [CNT_W-1:0]      rfifo_wr_cnt;
    logic [MEM_ADDR_W:0]   stored_cnt;
    logic                  busy;

    // Emulator side: drives the FIFO enables and status.
    modport master (
        output calib_done,
        output wfifo_rd_en,
        input  wfifo_dout,
        input  wfifo_rd_cnt,
        input  rd_mem_enable,
        output rfifo_wr_en,
        output rfifo_din,
        input  rfifo_wr_cnt,
        output stored_cnt,
        output busy
    );

    // FIFO / traffic-generator side.
    modport slave (
        input  calib_done,
        input  wfifo_rd_en,
        output wfifo_dout,
        output wfifo_rd_cnt,
        output rd_mem_enable,
        input  rfifo_wr_en,
        input  rfifo_din,
        output rfifo_wr_cnt,
        input  stored_cnt,
        input  busy
    );
endinterface

// File: rtl/ddr_loopback_emu.sv
// Behavioural DDR3-controller stand-in: drains fixed-size bursts from the write
// FIFO into a circular on-chip memory and streams them back, in order, into the
// read FIFO while rd_mem_enable is high. Emulates calibration with a fixed delay.
module ddr_loopback_emu #(
    parameter int DATA_W       = 16,
    parameter int BURST_LEN    = 64,
    parameter int MEM_ADDR_W   = 10,
    parameter int CNT_W        = 11,
    parameter int RFIFO_DEPTH  = 1024,
    parameter int CALIB_CYCLES = 30
) (
    input  logic           clk,
    input  logic           rst_n,
    ddr_loopback_if.master bus,
    output logic [1:0]     state_o
);

    localparam int MEM_DEPTH = 1 << MEM_ADDR_W;
    localparam int SC_W      = MEM_ADDR_W + 1;
    localparam int BEAT_W    = $clog2(BURST_LEN + 1);
    localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);

    // Sized thresholds so every comparison is width-matched.
    localparam logic [CNT_W-1:0]  WCNT_MIN        = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0]  RCNT_MAX        = CNT_W'(RFIFO_DEPTH - BURST_LEN);
    localparam logic [SC_W-1:0]   SC_WR_MAX       = SC_W'(MEM_DEPTH - BURST_LEN);
    localparam logic [SC_W-1:0]   SC_BURST        = SC_W'(BURST_LEN);
    localparam logic [BEAT_W-1:0] BEAT_ISSUE_LAST = BEAT_W'(BURST_LEN - 1);
    localparam logic [BEAT_W-1:0] BEAT_TRAIL      = BEAT_W'(BURST_LEN);
    localparam logic [CAL_W-1:0]  CAL_END         = CAL_W'(CALIB_CYCLES);

    typedef enum logic [1:0] {
        ST_CALIB = 2'd0,
        ST_IDLE  = 2'd1,
        ST_WR    = 2'd2,
        ST_RD    = 2'd3
    } state_t;

    state_t                state_q;
    logic [CAL_W-1:0]      calib_cnt_q;
    logic [BEAT_W-1:0]     beat_q;
    logic [MEM_ADDR_W-1:0] wr_ptr_q;
    logic [MEM_ADDR_W-1:0] rd_ptr_q;
    logic [SC_W-1:0]       stored_cnt_q;
    logic                  last_wr_q;
    logic                  calib_done_q;
    logic                  busy_q;
    logic                  wfifo_rd_en_q;
    logic                  cap_q;
    logic                  rfifo_wr_en_q;
    logic [DATA_W-1:0]     rdata_q;

    logic [DATA_W-1:0]     mem [MEM_DEPTH];

    logic wr_ok;
    logic rd_ok;
    logic pick_wr_d;
    logic pick_rd_d;
    logic rd_issue;

    // Burst eligibility, evaluated against the counts seen while idle.
    assign wr_ok = (bus.wfifo_rd_cnt >= WCNT_MIN) && (stored_cnt_q <= SC_WR_MAX);
    assign rd_ok = bus.rd_mem_enable && (stored_cnt_q >= SC_BURST) &&
                   (bus.rfifo_wr_cnt <= RCNT_MAX);

    // Round-robin when both are eligible: take the opposite of the last burst.
    // last_wr_q resets low so a write wins the first contest after reset.
    assign pick_wr_d = wr_ok && (!rd_ok || !last_wr_q);
    assign pick_rd_d = rd_ok && !pick_wr_d;

    // A memory read is issued on each of the first BURST_LEN read-burst clocks.
    assign rd_issue = (state_q == ST_RD) && (beat_q != BEAT_TRAIL);

    // Main controller: calibration delay, arbitration, burst sequencing, pointers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_CALIB;
            calib_cnt_q   <= '0;
            beat_q        <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            stored_cnt_q  <= '0;
            last_wr_q     <= 1'b0;
            calib_done_q  <= 1'b0;
            busy_q        <= 1'b0;
            wfifo_rd_en_q <= 1'b0;
            cap_q         <= 1'b0;
            rfifo_wr_en_q <= 1'b0;
        end else begin
            case (state_q)
                ST_CALIB: begin
                    if (calib_cnt_q == CAL_END) begin
                        state_q      <= ST_IDLE;
                        calib_done_q <= 1'b1;
                    end else begin
                        calib_cnt_q <= calib_cnt_q + 1'b1;
                    end
                end

                ST_IDLE: begin
                    beat_q <= '0;
                    if (pick_wr_d) begin
                        state_q       <= ST_WR;
                        busy_q        <= 1'b1;
                        wfifo_rd_en_q <= 1'b1;
                        last_wr_q     <= 1'b1;
                    end else if (pick_rd_d) begin
                        state_q   <= ST_RD;
                        busy_q    <= 1'b1;
                        last_wr_q <= 1'b0;
                    end
                end

                // Pops on beats 0..BURST_LEN-1; each word is captured one clock
                // later, so the last capture lands on the trailing beat.
                ST_WR: begin
                    beat_q        <= beat_q + 1'b1;
                    wfifo_rd_en_q <= (beat_q < BEAT_ISSUE_LAST);
                    cap_q         <= wfifo_rd_en_q;
                    if (cap_q) begin
                        wr_ptr_q <= wr_ptr_q + 1'b1;
                    end
                    if (beat_q == BEAT_TRAIL) begin
                        stored_cnt_q <= stored_cnt_q + SC_BURST;
                        state_q      <= ST_IDLE;
                        busy_q       <= 1'b0;
                    end
                end

                // Addresses on beats 0..BURST_LEN-1; the read FIFO write strobe
                // follows each address by one clock, ending on the trailing beat.
                ST_RD: begin
                    beat_q        <= beat_q + 1'b1;
                    rfifo_wr_en_q <= rd_issue;
                    if (rd_issue) begin
                        rd_ptr_q <= rd_ptr_q + 1'b1;
                    end
                    if (beat_q == BEAT_ISSUE_LAST) begin
                        stored_cnt_q <= stored_cnt_q - SC_BURST;
                    end
                    if (beat_q == BEAT_TRAIL) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= ST_CALIB;
                end
            endcase
        end
    end

    // Circular storage: synchronous write of captured words, synchronous read.
    always_ff @(posedge clk) begin
        if (cap_q) begin
            mem[wr_ptr_q] <= bus.wfifo_dout;
        end
        if (rd_issue) begin
            rdata_q <= mem[rd_ptr_q];
        end
    end

    // Read data is only presented alongside its strobe so the bus reads zero
    // otherwise (including straight out of reset).
    assign bus.rfifo_din   = rfifo_wr_en_q ? rdata_q : '0;
    assign bus.rfifo_wr_en = rfifo_wr_en_q;
    assign bus.wfifo_rd_en = wfifo_rd_en_q;
    assign bus.calib_done  = calib_done_q;
    assign bus.stored_cnt  = stored_cnt_q;
    assign bus.busy        = busy_q;
    assign state_o         = state_q;

endmodule
